reg_native_slv_array: RTL and testbench
=======================================

Name: reg_native_slv_array

Overview:
- Parametrised register-slave array on the reg_native_if (req/ack) bus, downstream of a regmst.
- Holds REG_NUM registers of DATA_WIDTH bits.
- Each register's software onwrite mode (na/woclr/woset/wot/wzc/wzs/wzt/ro), onread side effect (none/rclr/rset) and reset value are set per register by parameter.
- Adds hardware pulse updates, a global sync reset and a backpressured ack channel.

Parameters:
- ADDR_WIDTH, 64, bus address width.
- DATA_WIDTH, 32, register and bus data width (power of two, >=8).
- REG_NUM, 8, number of registers (1..64).
- BASE_ADDR, 0, byte address of register 0; stride is DATA_WIDTH/8 bytes.
- ONWRITE, {REG_NUM{4'd0}}, packed 4-bit mode per register: 0 na(plain write), 1 woclr, 2 woset, 3 wot, 4 wzc, 5 wzs, 6 wzt, 7 ro.
- ONREAD, {REG_NUM{2'd0}}, packed 2-bit per register: 0 none, 1 rclr, 2 rset.
- RESET_VAL, 0, packed REG_NUM*DATA_WIDTH reset values.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- addr  in  ADDR_WIDTH  byte address.
- wr_data  in  DATA_WIDTH  write data.
- ack_vld  out  1  response valid.
- ack_rdy  in  1  response accepted.
- rd_data  out  DATA_WIDTH  read data, valid with ack_vld.
- global_sync_reset_in  in  1  synchronous reload of all registers.
- hw_next_value  in  REG_NUM*DATA_WIDTH  hardware load values.
- hw_pulse  in  REG_NUM  per-register hardware load strobe.
- hw_curr_value  out  REG_NUM*DATA_WIDTH  current register contents.

Behaviour:
- Reset (rst=1, async): registers=RESET_VAL, FSM=IDLE, req_rdy=1, ack_vld=0, rd_data=0.
- FSM IDLE: req_rdy=1. Acceptance = req_vld&&req_rdy → go to ACK.
- FSM ACK: req_rdy=0, ack_vld=1; rd_data and ack_vld held stable until ack_rdy=1; then return to IDLE. This gives one outstanding transaction.
- Timing: ack_vld rises the cycle after acceptance. Register update from a write or read side effect is visible on hw_curr_value the cycle after acceptance. Back-to-back throughput is one transaction per 2 cycles when ack_rdy is held high.
- Decode: idx = (addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
  - Hit requires addr>=BASE_ADDR, idx<REG_NUM and addr aligned.
  - Miss: no register effect, rd_data=0, normal ack.
- Write next value (cur, d=wr_data):
  - na: d
  - woclr: cur&~d
  - woset: cur|d
  - wot: cur^d
  - wzc: cur&d
  - wzs: cur|~d
  - wzt: cur^~d
  - ro: cur
- Read: rd_data = value before the side effect. rclr → all 0; rset → all 1.
- wr_en&&rd_en: treated as write only. Neither set: ack with rd_data=0, no effect.
- Priority per register, highest first:
  1. global_sync_reset_in (loads RESET_VAL)
  2. sw access at acceptance
  3. hw_pulse (loads hw_next_value)
- A hw_pulse coinciding with a sw access to the same register is dropped. A hw_pulse to a different register applies.
- global_sync_reset_in does not affect the FSM. A pending ack completes with its captured rd_data.
- rst asserted mid-ACK: ack dropped immediately, FSM returns to IDLE.

Optional Feature:
- Macro: REG_NATIVE_SLV_ADDR_ERR_EN.
- Defined:
  - Adds output ack_err (1 bit), registered alongside ack_vld.
  - ack_err=1 for a miss, a misaligned address, or a write to an ro register.
  - ack_err=0 otherwise; reset 0.
  - The ro write still has no effect.
- Undefined: port absent; errors are silent.

Decomposition:
- Package reg_native_slv_pkg holds:
  - onwrite_e and onread_e enums
  - FSM state enum {IDLE, ACK}
  - function sw_write_next(cur, d, mode)
  - function sw_read_next(cur, mode)
- Sub-module reg_native_slv_field: one register holding RESET_VAL/ONWRITE/ONREAD, with inputs sw_wr, sw_rd, wr_data, hw_pulse, hw_next, sync_rst. Generated REG_NUM times.
- Top level: decode, FSM, read mux.

Test Plan:
- Reset, then per mode write 0x00000000 then 0xFFFFFFFF to a register with reset 0xA5A5A5A5 → hw_curr_value after each write:
  - na: 0x0 then 0xFFFFFFFF
  - woclr: 0xA5A5A5A5 then 0x0
  - woset: 0xA5A5A5A5 then 0xFFFFFFFF
  - wot: 0xA5A5A5A5 then 0x5A5A5A5A
  - wzc: 0x0 then 0x0
  - wzs: 0xFFFFFFFF then 0xFFFFFFFF
  - wzt: 0x5A5A5A5A then 0x5A5A5A5A
  - ro: unchanged
- rclr register at 0x12345678, read → rd_data=0x12345678, next read 0x0. rset register → second read 0xFFFFFFFF.
- Hold ack_rdy=0 for 5 cycles after a read → ack_vld and rd_data stable, req_rdy=0. Assert ack_rdy → FSM idles the next cycle.
- hw_pulse with next=0xDEADBEEF in the same cycle as a na write of 0x1 to that register → value 0x1. Pulse alone the next cycle → 0xDEADBEEF.
- global_sync_reset_in during a pending ack → registers return to RESET_VAL; ack completes with the pre-reset rd_data.
- Access to BASE_ADDR+REG_NUM*4 → rd_data=0, no register change. With REG_NATIVE_SLV_ADDR_ERR_EN defined → ack_err=1.

Source files
------------

// File: rtl/reg_native_slv_pkg.sv
// Shared types and software access-side-effect functions for the register slave array.
package reg_native_slv_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 1024;
  typedef logic [MAX_DATA_WIDTH-1:0] word_t;

  typedef enum logic [3:0] {
    OW_NA    = 4'd0,
    OW_WOCLR = 4'd1,
    OW_WOSET = 4'd2,
    OW_WOT   = 4'd3,
    OW_WZC   = 4'd4,
    OW_WZS   = 4'd5,
    OW_WZT   = 4'd6,
    OW_RO    = 4'd7
  } onwrite_e;

  typedef enum logic [1:0] {
    OR_NONE = 2'd0,
    OR_RCLR = 2'd1,
    OR_RSET = 2'd2
  } onread_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // Functions work on the widest supported word; callers truncate to their width.
  function automatic word_t sw_write_next(word_t cur, word_t d, onwrite_e mode);
    case (mode)
      OW_NA:    return d;
      OW_WOCLR: return cur & ~d;
      OW_WOSET: return cur | d;
      OW_WOT:   return cur ^ d;
      OW_WZC:   return cur & d;
      OW_WZS:   return cur | ~d;
      OW_WZT:   return cur ^ ~d;
      default:  return cur;
    endcase
  endfunction

  function automatic word_t sw_read_next(word_t cur, onread_e mode);
    case (mode)
      OR_RCLR: return '0;
      OR_RSET: return '1;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/reg_native_slv_if.sv
// req/ack native register bus; ack_err exists only with REG_NATIVE_SLV_ADDR_ERR_EN.
interface reg_native_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic                  ack_rdy;
  logic [DATA_WIDTH-1:0] rd_data;
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
  logic                  ack_err;
`endif

  modport master (
    output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    input  ack_err,
`endif
    input  req_rdy, ack_vld, rd_data
  );

  modport slave (
    input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    output ack_err,
`endif
    output req_rdy, ack_vld, rd_data
  );
endinterface

// File: rtl/reg_native_slv_field.sv
// One software/hardware accessible register with fixed write mode, read side effect and reset value.
module reg_native_slv_field
  import reg_native_slv_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter onwrite_e              ONWRITE    = OW_NA,
  parameter onread_e               ONREAD     = OR_NONE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_rst,
  input  logic                  sw_wr,
  input  logic                  sw_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  hw_pulse,
  input  logic [DATA_WIDTH-1:0] hw_next,
  output logic [DATA_WIDTH-1:0] value
);

  // Sync reset beats software access, which beats (and swallows) a hardware pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= RESET_VAL;
    else if (sync_rst)
      value <= RESET_VAL;
    else if (sw_wr)
      value <= DATA_WIDTH'(sw_write_next(word_t'(value), word_t'(wr_data), ONWRITE));
    else if (sw_rd)
      value <= DATA_WIDTH'(sw_read_next(word_t'(value), ONREAD));
    else if (hw_pulse)
      value <= hw_next;
  end

endmodule

// File: rtl/reg_native_slv_array.sv
// Register slave array: address decode, single-outstanding req/ack FSM, read mux.
// Optional ack_err output enabled by REG_NATIVE_SLV_ADDR_ERR_EN.
module reg_native_slv_array
  import reg_native_slv_pkg::*;
#(
  parameter int unsigned                    ADDR_WIDTH = 64,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    REG_NUM    = 8,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [4*REG_NUM-1:0]           ONWRITE    = '0,
  parameter logic [2*REG_NUM-1:0]           ONREAD     = '0,
  parameter logic [REG_NUM*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  reg_native_if.slave                   bus,
  input  logic                          global_sync_reset_in,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_next_value,
  input  logic [REG_NUM-1:0]            hw_pulse,
  output logic [REG_NUM*DATA_WIDTH-1:0] hw_curr_value
);

  localparam int unsigned           LSB        = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  state_e                  state, state_nxt;
  logic                    req_rdy, ack_vld, accept;
  logic [ADDR_WIDTH-1:0]   offset, idx;
  logic                    hit;
  logic [REG_NUM-1:0]      sel, sw_wr, sw_rd;
  logic [DATA_WIDTH-1:0]   cur [REG_NUM];
  logic [DATA_WIDTH-1:0]   rd_mux, rd_data;

  always_comb begin
    offset = bus.addr - BASE_ADDR;
    idx    = offset >> LSB;
    hit    = (bus.addr >= BASE_ADDR) && ((offset & ALIGN_MASK) == '0) &&
             (idx < ADDR_WIDTH'(REG_NUM));
    sel    = '0;
    rd_mux = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      sel[i] = hit && (idx == ADDR_WIDTH'(i));
      if (sel[i] && bus.rd_en && !bus.wr_en)
        rd_mux = cur[i];
    end
  end

  assign accept = bus.req_vld && req_rdy;
  assign sw_wr  = {REG_NUM{accept && bus.wr_en}} & sel;
  assign sw_rd  = {REG_NUM{accept && !bus.wr_en && bus.rd_en}} & sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    ack_vld   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_vld) state_nxt = ACK;
      end
      ACK: begin
        ack_vld = 1'b1;
        if (bus.ack_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is captured at acceptance, i.e. before any read side effect lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '0;
    else if (accept) rd_data <= rd_mux;
  end

  assign bus.req_rdy = req_rdy;
  assign bus.ack_vld = ack_vld;
  assign bus.rd_data = rd_data;

`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
  logic ro_wr, ack_err;

  always_comb begin
    ro_wr = 1'b0;
    for (int unsigned i = 0; i < REG_NUM; i++)
      if (sel[i] && bus.wr_en && (ONWRITE[4*i +: 4] == 4'(OW_RO)))
        ro_wr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ack_err <= 1'b0;
    else if (accept) ack_err <= !hit || ro_wr;
  end

  assign bus.ack_err = ack_err;
`endif

  for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
    reg_native_slv_field #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL[DATA_WIDTH*i +: DATA_WIDTH]),
      .ONWRITE    (onwrite_e'(ONWRITE[4*i +: 4])),
      .ONREAD     (onread_e'(ONREAD[2*i +: 2]))
    ) u_field (
      .clk      (clk),
      .rst      (rst),
      .sync_rst (global_sync_reset_in),
      .sw_wr    (sw_wr[i]),
      .sw_rd    (sw_rd[i]),
      .wr_data  (bus.wr_data),
      .hw_pulse (hw_pulse[i]),
      .hw_next  (hw_next_value[DATA_WIDTH*i +: DATA_WIDTH]),
      .value    (cur[i])
    );
    assign hw_curr_value[DATA_WIDTH*i +: DATA_WIDTH] = cur[i];
  end

endmodule

// File: tb/tb_reg_native_slv_array.sv
// Directed bench for reg_native_slv_array: 10 registers (8 write modes, rclr, rset) at base 0x100.
module tb_reg_native_slv_array;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned RN = 10;
  localparam logic [AW-1:0] BASE = 64'h100;
  localparam logic [4*RN-1:0] OW = {4'd0, 4'd0, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [2*RN-1:0] ORD = {2'd2, 2'd1, 16'd0};
  localparam logic [RN*DW-1:0] RV = {32'h12345678, 32'h12345678, {8{32'hA5A5A5A5}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              gsr;
  logic [RN*DW-1:0]  hw_next;
  logic [RN*DW-1:0]  hw_curr;
  logic [RN-1:0]     hw_pulse;

  reg_native_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_native_slv_array #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .REG_NUM    (RN),
    .BASE_ADDR  (BASE),
    .ONWRITE    (OW),
    .ONREAD     (ORD),
    .RESET_VAL  (RV)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .global_sync_reset_in (gsr),
    .hw_next_value        (hw_next),
    .hw_pulse             (hw_pulse),
    .hw_curr_value        (hw_curr)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] reg_val(int unsigned i);
    return hw_curr[32*i +: 32];
  endfunction

  task automatic bus_xfer(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] q, output logic e);
    int cnt;
    @(negedge clk);
    bus.req_vld = 1'b1; bus.wr_en = w; bus.rd_en = r; bus.addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    cnt = 0;
    while (bus.ack_vld !== 1'b1 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL ack_latency addr=%h waited=%0d cycles required=0", a, cnt);
    end
    q = bus.rd_data;
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    e = bus.ack_err;
`else
    e = 1'b0;
`endif
    bus.ack_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gsr = 1'b0; hw_pulse = '0; hw_next = '0;
    bus.req_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.addr = '0; bus.wr_data = '0; bus.ack_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got=%b exp=1", bus.req_rdy); end
    checks++; if (bus.ack_vld !== 1'b0) begin errors++; $display("FAIL reset_ack_vld got=%b exp=0", bus.ack_vld); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    checks++; if (hw_curr !== RV) begin errors++; $display("FAIL reset_regs got=%h exp=%h", hw_curr, RV); end
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_onwrite();
    logic [31:0] exp0 [8] = '{32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                              32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5};
    logic [31:0] exp1 [8] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A,
                              32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5};
    logic [31:0] q;
    logic e;
    for (int unsigned m = 0; m < 8; m++) begin
      bus_xfer(1'b1, 1'b0, BASE + 64'(4*m), 32'h0, q, e);
      checks++;
      if (reg_val(m) !== exp0[m]) begin
        errors++; $display("FAIL onwrite_zero mode=%0d got=%h exp=%h", m, reg_val(m), exp0[m]);
      end
      bus_xfer(1'b1, 1'b0, BASE + 64'(4*m), 32'hFFFFFFFF, q, e);
      checks++;
      if (reg_val(m) !== exp1[m]) begin
        errors++; $display("FAIL onwrite_ones mode=%0d got=%h exp=%h", m, reg_val(m), exp1[m]);
      end
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
      checks++;
      if (e !== (m == 7)) begin
        errors++; $display("FAIL onwrite_err mode=%0d got=%b exp=%b", m, e, (m == 7));
      end
`endif
    end
    bus_xfer(1'b0, 1'b1, BASE + 64'd12, 32'h0, q, e);
    checks++; if (q !== 32'h5A5A5A5A) begin errors++; $display("FAIL plain_read got=%h exp=5a5a5a5a", q); end
  endtask

  task automatic test_onread();
    logic [31:0] q;
    logic e;
    bus_xfer(1'b0, 1'b1, BASE + 64'd32, 32'h0, q, e);
    checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL rclr_first got=%h exp=12345678", q); end
    checks++; if (reg_val(8) !== 32'h0) begin errors++; $display("FAIL rclr_effect got=%h exp=0", reg_val(8)); end
    bus_xfer(1'b0, 1'b1, BASE + 64'd32, 32'h0, q, e);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rclr_second got=%h exp=0", q); end
    bus_xfer(1'b0, 1'b1, BASE + 64'd36, 32'h0, q, e);
    checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL rset_first got=%h exp=12345678", q); end
    bus_xfer(1'b0, 1'b1, BASE + 64'd36, 32'h0, q, e);
    checks++; if (q !== 32'hFFFFFFFF) begin errors++; $display("FAIL rset_second got=%h exp=ffffffff", q); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.ack_rdy = 1'b0;
    bus.req_vld = 1'b1; bus.rd_en = 1'b1; bus.addr = BASE;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.ack_vld !== 1'b1 || bus.rd_data !== 32'hFFFFFFFF || bus.req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall cyc=%0d got ack_vld=%b rd_data=%h req_rdy=%b exp 1/ffffffff/0",
                 i, bus.ack_vld, bus.rd_data, bus.req_rdy);
      end
      @(posedge clk); #1;
    end
    bus.ack_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ack_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      errors++; $display("FAIL stall_release got ack_vld=%b req_rdy=%b exp 0/1", bus.ack_vld, bus.req_rdy);
    end
  endtask

  task automatic test_hw_pulse();
    @(negedge clk);
    bus.req_vld = 1'b1; bus.wr_en = 1'b1; bus.addr = BASE; bus.wr_data = 32'h1;
    hw_pulse = 10'b00_0000_0011;
    hw_next[31:0] = 32'hDEADBEEF; hw_next[63:32] = 32'h0000CAFE;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.wr_en = 1'b0; hw_pulse = '0;
    checks++; if (bus.ack_vld !== 1'b1) begin errors++; $display("FAIL pulse_ack got=%b exp=1", bus.ack_vld); end
    checks++; if (reg_val(0) !== 32'h1) begin errors++; $display("FAIL pulse_collide got=%h exp=00000001", reg_val(0)); end
    checks++; if (reg_val(1) !== 32'h0000CAFE) begin errors++; $display("FAIL pulse_other got=%h exp=0000cafe", reg_val(1)); end
    @(posedge clk); #1;
    hw_pulse = 10'b00_0000_0001;
    @(posedge clk); #1;
    hw_pulse = '0;
    checks++; if (reg_val(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL pulse_alone got=%h exp=deadbeef", reg_val(0)); end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    bus.ack_rdy = 1'b0;
    bus.req_vld = 1'b1; bus.rd_en = 1'b1; bus.addr = BASE + 64'd12;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.rd_en = 1'b0;
    gsr = 1'b1;
    @(posedge clk); #1;
    gsr = 1'b0;
    checks++; if (hw_curr !== RV) begin errors++; $display("FAIL sync_rst_regs got=%h exp=%h", hw_curr, RV); end
    checks++;
    if (bus.ack_vld !== 1'b1 || bus.rd_data !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL sync_rst_ack got ack_vld=%b rd_data=%h exp 1/5a5a5a5a", bus.ack_vld, bus.rd_data);
    end
    bus.ack_rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL sync_rst_idle got=%b exp=1", bus.req_rdy); end
  endtask

  task automatic test_miss();
    logic [31:0] q;
    logic e;
    bus_xfer(1'b0, 1'b1, BASE + 64'd40, 32'h0, q, e);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL miss_rd_data got=%h exp=0", q); end
    checks++; if (hw_curr !== RV) begin errors++; $display("FAIL miss_regs got=%h exp=%h", hw_curr, RV); end
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL miss_err got=%b exp=1", e); end
`endif
    bus_xfer(1'b1, 1'b0, BASE + 64'd2, 32'h0, q, e);
    checks++; if (reg_val(0) !== 32'hA5A5A5A5) begin errors++; $display("FAIL misalign_reg got=%h exp=a5a5a5a5", reg_val(0)); end
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", e); end
`endif
    bus_xfer(1'b1, 1'b1, BASE, 32'h00001234, q, e);
    checks++;
    if (q !== 32'h0 || reg_val(0) !== 32'h00001234) begin
      errors++; $display("FAIL wr_and_rd got rd=%h reg=%h exp 0/00001234", q, reg_val(0));
    end
`ifdef REG_NATIVE_SLV_ADDR_ERR_EN
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_and_rd_err got=%b exp=0", e); end
`endif
    bus_xfer(1'b0, 1'b0, BASE + 64'd32, 32'h0, q, e);
    checks++;
    if (q !== 32'h0 || reg_val(8) !== 32'h12345678) begin
      errors++; $display("FAIL no_op got rd=%h reg=%h exp 0/12345678", q, reg_val(8));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.ack_rdy = 1'b1;
    bus.req_vld = 1'b1; bus.wr_en = 1'b1; bus.addr = BASE; bus.wr_data = 32'h1;
    @(posedge clk); #1;
    bus.wr_data = 32'h2;
    checks++;
    if (bus.ack_vld !== 1'b1 || bus.req_rdy !== 1'b0 || reg_val(0) !== 32'h1) begin
      errors++; $display("FAIL b2b_first got ack=%b rdy=%b reg=%h exp 1/0/00000001", bus.ack_vld, bus.req_rdy, reg_val(0));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ack_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got ack=%b rdy=%b exp 0/1", bus.ack_vld, bus.req_rdy);
    end
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.wr_en = 1'b0;
    checks++;
    if (bus.ack_vld !== 1'b1 || reg_val(0) !== 32'h2) begin
      errors++; $display("FAIL b2b_second got ack=%b reg=%h exp 1/00000002", bus.ack_vld, reg_val(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_rst();
    @(negedge clk);
    bus.ack_rdy = 1'b0;
    bus.req_vld = 1'b1; bus.rd_en = 1'b1; bus.addr = BASE;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.rd_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ack_vld !== 1'b0 || bus.req_rdy !== 1'b1 || reg_val(0) !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL async_rst got ack=%b rdy=%b reg=%h exp 0/1/a5a5a5a5", bus.ack_vld, bus.req_rdy, reg_val(0));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ack_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_onwrite();
    test_onread();
    test_backpressure();
    test_hw_pulse();
    test_sync_reset();
    test_miss();
    test_back_to_back();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
